// File: rtl/voice_allocator.sv
// Four-voice note allocator: each note-on is routed to a voice datapath through a
// one-hot load strobe. When every voice is busy, the least-recently-loaded voice
// is stolen; with stealing disabled, the event is dropped instead. Note-offs
// release the matching voice.
module voice_allocator #(
    parameter bit STEAL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       note_on,
    input  logic       note_off,
    input  logic [3:0] note,
    input  logic [2:0] octave,
    output logic [3:0] voice_ld,
    output logic [3:0] voice_note,
    output logic [2:0] voice_oct,
    output logic [3:0] voice_active,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam int unsigned NV  = 4;
    localparam int unsigned NW  = 4;
    localparam int unsigned OW  = 3;
    localparam int unsigned AW  = 2;
    localparam int unsigned IW  = 2;
    localparam int unsigned DW  = 8;
    localparam int unsigned DSW = DW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        LOAD    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [NW-1:0]           note_cap_q, note_cap_d;
    logic [OW-1:0]           oct_cap_q, oct_cap_d;
    logic                    rel_q, rel_d;
    logic [IW-1:0]           target_q, target_d;
    logic [NV-1:0]           active_q, active_d;
    logic [NV-1:0][AW-1:0]   age_q, age_d;
    logic [NV-1:0][NW-1:0]   key_note_q, key_note_d;
    logic [NV-1:0][OW-1:0]   key_oct_q, key_oct_d;
    logic [NV-1:0]           voice_ld_q, voice_ld_d;
    logic [NW-1:0]           voice_note_q, voice_note_d;
    logic [OW-1:0]           voice_oct_q, voice_oct_d;
    logic [NV-1:0]           voice_active_q, voice_active_d;
    logic                    busy_q, busy_d;
    logic [DW-1:0]           drop_cnt_q, drop_cnt_d;

    logic [NV-1:0]           match_c;
    logic                    hit_c, free_c, old_c;
    logic [IW-1:0]           hit_idx_c, free_idx_c, old_idx_c;
    logic [1:0]              drop_inc;
    logic [DSW-1:0]          drop_sum;
    logic [AW-1:0]           tgt_age;

    // Parallel key match plus lowest-index free voice and oldest voice lookup
    always_comb begin
        match_c    = '0;
        hit_c      = 1'b0;
        free_c     = 1'b0;
        old_c      = 1'b0;
        hit_idx_c  = '0;
        free_idx_c = '0;
        old_idx_c  = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            match_c[i] = active_q[i] && (key_note_q[i] == note_cap_q)
                                     && (key_oct_q[i] == oct_cap_q);
            if (match_c[i]) begin
                hit_c     = 1'b1;
                hit_idx_c = IW'(i);
            end
            if (!active_q[i]) begin
                free_c     = 1'b1;
                free_idx_c = IW'(i);
            end
            if (active_q[i] && (age_q[i] == AW'(NV - 1))) begin
                old_c     = 1'b1;
                old_idx_c = IW'(i);
            end
        end
    end

    // Next-state, voice table update and registered output values
    always_comb begin
        state_d        = state_q;
        note_cap_d     = note_cap_q;
        oct_cap_d      = oct_cap_q;
        rel_d          = rel_q;
        target_d       = target_q;
        active_d       = active_q;
        age_d          = age_q;
        key_note_d     = key_note_q;
        key_oct_d      = key_oct_q;
        voice_ld_d     = '0;
        voice_note_d   = voice_note_q;
        voice_oct_d    = voice_oct_q;
        voice_active_d = active_q;
        drop_inc       = 2'd0;
        tgt_age        = age_q[target_q];

        // Any event seen outside IDLE is discarded
        if ((state_q != IDLE) && (note_on || note_off)) begin
            drop_inc = drop_inc + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (note_on) begin
                    note_cap_d = note;
                    oct_cap_d  = octave;
                    rel_d      = 1'b0;
                    state_d    = SEARCH;
                    if (note_off) begin
                        drop_inc = drop_inc + 2'd1;
                    end
                end else if (note_off) begin
                    note_cap_d = note;
                    oct_cap_d  = octave;
                    rel_d      = 1'b1;
                    state_d    = SEARCH;
                end
            end
            SEARCH: begin
                if (rel_q) begin
                    target_d = hit_idx_c;
                    state_d  = hit_c ? RELEASE : IDLE;
                end else if (hit_c) begin
                    target_d = hit_idx_c;
                    state_d  = LOAD;
                end else if (free_c) begin
                    target_d = free_idx_c;
                    state_d  = LOAD;
                end else if (STEAL_EN && old_c) begin
                    target_d = old_idx_c;
                    state_d  = LOAD;
                end else begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = IDLE;
                end
            end
            LOAD: begin
                voice_ld_d[target_q] = 1'b1;
                voice_note_d         = note_cap_q;
                voice_oct_d          = oct_cap_q;
                key_note_d[target_q] = note_cap_q;
                key_oct_d[target_q]  = oct_cap_q;
                // A retrigger only ages voices younger than the retriggered one
                for (int i = 0; i < NV; i++) begin
                    if ((IW'(i) != target_q) && active_q[i] &&
                        (!active_q[target_q] || (age_q[i] < tgt_age))) begin
                        age_d[i] = AW'(age_q[i] + AW'(1));
                    end
                end
                age_d[target_q]    = '0;
                active_d[target_q] = 1'b1;
                state_d            = IDLE;
            end
            RELEASE: begin
                // Close the gap left by the released voice
                for (int i = 0; i < NV; i++) begin
                    if (active_q[i] && (age_q[i] > tgt_age)) begin
                        age_d[i] = AW'(age_q[i] - AW'(1));
                    end
                end
                age_d[target_q]    = '0;
                active_d[target_q] = 1'b0;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        drop_sum   = {1'b0, drop_cnt_q} + DSW'(drop_inc);
        drop_cnt_d = drop_sum[DW] ? '1 : drop_sum[DW-1:0];
    end

    // State, voice table and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            note_cap_q     <= '0;
            oct_cap_q      <= '0;
            rel_q          <= 1'b0;
            target_q       <= '0;
            active_q       <= '0;
            age_q          <= '0;
            key_note_q     <= '0;
            key_oct_q      <= '0;
            voice_ld_q     <= '0;
            voice_note_q   <= '0;
            voice_oct_q    <= '0;
            voice_active_q <= '0;
            busy_q         <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            note_cap_q     <= note_cap_d;
            oct_cap_q      <= oct_cap_d;
            rel_q          <= rel_d;
            target_q       <= target_d;
            active_q       <= active_d;
            age_q          <= age_d;
            key_note_q     <= key_note_d;
            key_oct_q      <= key_oct_d;
            voice_ld_q     <= voice_ld_d;
            voice_note_q   <= voice_note_d;
            voice_oct_q    <= voice_oct_d;
            voice_active_q <= voice_active_d;
            busy_q         <= busy_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign voice_ld     = voice_ld_q;
    assign voice_note   = voice_note_q;
    assign voice_oct    = voice_oct_q;
    assign voice_active = voice_active_q;
    assign busy         = busy_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: one instance with stealing, one without.
module tb_voice_allocator;

    logic       clk;
    logic       reset;
    logic       note_on;
    logic       note_off;
    logic [3:0] note;
    logic [2:0] octave;

    logic [3:0] voice_ld, voice_note, voice_active;
    logic [2:0] voice_oct;
    logic       busy;
    logic [7:0] drop_cnt;

    logic [3:0] ns_voice_ld, ns_voice_note, ns_voice_active;
    logic [2:0] ns_voice_oct;
    logic       ns_busy;
    logic [7:0] ns_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    voice_allocator #(.STEAL_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .note_on(note_on), .note_off(note_off),
        .note(note), .octave(octave), .voice_ld(voice_ld), .voice_note(voice_note),
        .voice_oct(voice_oct), .voice_active(voice_active), .busy(busy),
        .drop_cnt(drop_cnt)
    );

    voice_allocator #(.STEAL_EN(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .note_on(note_on), .note_off(note_off),
        .note(note), .octave(octave), .voice_ld(ns_voice_ld), .voice_note(ns_voice_note),
        .voice_oct(ns_voice_oct), .voice_active(ns_voice_active), .busy(ns_busy),
        .drop_cnt(ns_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an event for exactly one sampling edge; returns half a cycle after it
    task automatic fire(input logic on, input logic off, input logic [3:0] n, input logic [2:0] o);
        @(negedge clk);
        note_on  = on;
        note_off = off;
        note     = n;
        octave   = o;
        @(negedge clk);
        note_on  = 1'b0;
        note_off = 1'b0;
    endtask

    // Note-on with full latency profile check; ages packed {v3,v2,v1,v0}
    task automatic load_check(input string tag, input logic [3:0] n, input logic [2:0] o,
                              input logic [3:0] exp_ld, input logic [3:0] exp_act,
                              input logic [7:0] exp_age);
        fire(1'b1, 1'b0, n, o);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_ld_early"}, 32'(voice_ld), 32'd0);
        @(negedge clk);
        chk({tag, "_ld"}, 32'(voice_ld), 32'(exp_ld));
        chk({tag, "_note"}, 32'(voice_note), 32'(n));
        chk({tag, "_oct"}, 32'(voice_oct), 32'(o));
        @(negedge clk);
        chk({tag, "_ld_off"}, 32'(voice_ld), 32'd0);
        chk({tag, "_active"}, 32'(voice_active), 32'(exp_act));
        chk({tag, "_age"}, 32'(dut.age_q), 32'(exp_age));
    endtask

    initial begin
        reset    = 1'b0;
        note_on  = 1'b0;
        note_off = 1'b0;
        note     = '0;
        octave   = '0;
        repeat (3) @(negedge clk);
        chk("rst_ld", 32'(voice_ld), 32'd0);
        chk("rst_note", 32'(voice_note), 32'd0);
        chk("rst_oct", 32'(voice_oct), 32'd0);
        chk("rst_active", 32'(voice_active), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ns_drop", 32'(ns_drop_cnt), 32'd0);
        reset = 1'b1;

        // Fill all four voices in order
        load_check("on1", 4'd1, 3'd4, 4'b0001, 4'b0001, 8'h00);
        load_check("on2", 4'd3, 3'd4, 4'b0010, 4'b0011, 8'h01);
        load_check("on3", 4'd5, 3'd4, 4'b0100, 4'b0111, 8'h06);
        load_check("on4", 4'd8, 3'd4, 4'b1000, 4'b1111, 8'h1B);

        // Fifth note steals voice0 (age 3); non-stealing instance drops it
        load_check("steal", 4'd10, 3'd4, 4'b0001, 4'b1111, 8'h6C);
        chk("ns_drop", 32'(ns_drop_cnt), 32'd1);
        chk("ns_note_held", 32'(ns_voice_note), 32'd8);
        chk("ns_active", 32'(ns_voice_active), 32'hF);
        chk("steal_nodrop", 32'(drop_cnt), 32'd0);

        // Retrigger of (3,4) in voice1
        load_check("retrig", 4'd3, 3'd4, 4'b0010, 4'b1111, 8'hB1);

        // Note-off (5,4) releases voice2 (age 3)
        fire(1'b0, 1'b1, 4'd5, 3'd4);
        chk("off_busy", 32'(busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("off_ld", 32'(voice_ld), 32'd0);
        chk("off_active_early", 32'(voice_active), 32'hF);
        @(negedge clk);
        chk("off_active", 32'(voice_active), 32'hB);
        chk("off_age", 32'(dut.age_q), 32'h81);

        // Freed voice2 is reused
        load_check("reuse", 4'd12, 3'd4, 4'b0100, 4'b1111, 8'hC6);

        // Simultaneous on/off: on wins (steals voice3), off counted as drop
        fire(1'b1, 1'b1, 4'd5, 3'd4);
        chk("both_drop", 32'(drop_cnt), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("both_ld", 32'(voice_ld), 32'h8);
        @(negedge clk);
        chk("both_age", 32'(dut.age_q), 32'h1B);

        // Event one cycle after a note-on is ignored
        @(negedge clk);
        note_on  = 1'b1;
        note     = 4'd3;
        octave   = 3'd4;
        @(negedge clk);
        note_on  = 1'b0;
        note_off = 1'b1;
        note     = 4'd8;
        @(negedge clk);
        note_off = 1'b0;
        chk("busy_drop", 32'(drop_cnt), 32'd2);
        chk("busy_hi", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_ld", 32'(voice_ld), 32'h2);
        chk("busy_note", 32'(voice_note), 32'd3);
        chk("busy_lo", 32'(busy), 32'd0);
        @(negedge clk);
        chk("busy_active", 32'(voice_active), 32'hF);
        chk("busy_age", 32'(dut.age_q), 32'h63);

        // Reset during SEARCH abandons the load
        fire(1'b1, 1'b0, 4'd9, 3'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ld", 32'(voice_ld), 32'd0);
        chk("mid_rst_note", 32'(voice_note), 32'd0);
        chk("mid_rst_oct", 32'(voice_oct), 32'd0);
        chk("mid_rst_active", 32'(voice_active), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_no_ld", 32'(voice_ld), 32'd0);
        chk("mid_rst_age", 32'(dut.age_q), 32'd0);

        // Note-off with no matching voice: no drop
        fire(1'b0, 1'b1, 4'd7, 3'd7);
        repeat (3) @(negedge clk);
        chk("off_miss_drop", 32'(drop_cnt), 32'd0);
        chk("off_miss_active", 32'(voice_active), 32'd0);

        // Drop counter saturates
        @(negedge clk);
        note_on  = 1'b1;
        note_off = 1'b1;
        note     = 4'd2;
        octave   = 3'd2;
        repeat (300) @(negedge clk);
        note_on  = 1'b0;
        note_off = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
